// File: rtl/mux_rr_reg.sv
// Registered N-channel mux with per-channel valid/ready handshake.
// Fixed-select or round-robin arbitration feeds a single output register.
module mux_rr_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [CHANNELS-1:0]       valid_i,
  output logic [CHANNELS-1:0]       ready_o,
  input  logic                      mode_i,
  input  logic [SEL_W-1:0]          select_i,
  output logic [WIDTH-1:0]          q_o,
  output logic [SEL_W-1:0]          q_chan_o,
  output logic                      q_valid_o,
  input  logic                      q_ready_i
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  int unsigned      sel_int;
  int unsigned      ptr_int;
  int unsigned      idx;

  assign load_en = !valid_q || q_ready_i;

  // Grant selection; round-robin takes the first valid channel at or above ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_int   = 32'(select_i);
    ptr_int   = 32'(ptr_q);
    idx       = 0;
    if (!mode_i) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (sel_int == k && valid_i[SEL_W'(k)]) begin
          gnt_found = 1'b1;
          gnt_idx   = SEL_W'(k);
        end
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        idx = ptr_int + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!gnt_found && valid_i[SEL_W'(idx)]) begin
          gnt_found = 1'b1;
          gnt_idx   = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (rst_n_i && gnt_found && load_en) ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        data_d = data_i[32'(gnt_idx)*WIDTH +: WIDTH];
        chan_d = gnt_idx;
        ptr_d  = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign q_o       = data_q;
  assign q_chan_o  = chan_q;
  assign q_valid_o = valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: a 4-channel and a 3-channel instance.
module tb_mux_rr_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        a_rst_n;
  logic [31:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic        a_mode;
  logic [1:0]  a_sel;
  logic [7:0]  a_q;
  logic [1:0]  a_chan;
  logic        a_qv, a_qr;

  // 3-channel instance
  logic        b_rst_n;
  logic [23:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [7:0]  b_q;
  logic [1:0]  b_chan;
  logic        b_qv, b_qr;

  int checks = 0;
  int errors = 0;

  mux_rr_reg #(.WIDTH(8), .CHANNELS(4)) u_dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n), .data_i(a_data), .valid_i(a_valid), .ready_o(a_ready),
    .mode_i(a_mode), .select_i(a_sel), .q_o(a_q), .q_chan_o(a_chan), .q_valid_o(a_qv),
    .q_ready_i(a_qr)
  );

  mux_rr_reg #(.WIDTH(8), .CHANNELS(3)) u_dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n), .data_i(b_data), .valid_i(b_valid), .ready_o(b_ready),
    .mode_i(b_mode), .select_i(b_sel), .q_o(b_q), .q_chan_o(b_chan), .q_valid_o(b_qv),
    .q_ready_i(b_qr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] q, input logic [1:0] ch,
                         input logic qv);
    check_eq({tag, ".q"}, 32'(a_q), 32'(q));
    check_eq({tag, ".chan"}, 32'(a_chan), 32'(ch));
    check_eq({tag, ".valid"}, 32'(a_qv), 32'(qv));
  endtask

  logic [7:0] rr_q [5];
  logic [1:0] rr_c [5];
  logic [1:0] alt_c [3];

  initial begin
    rr_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    rr_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    alt_c = '{2'd3, 2'd0, 2'd3};

    a_rst_n = 1'b0; a_data = 32'h4332_2110; a_valid = 4'b1111; a_mode = 1'b1;
    a_sel = 2'd0; a_qr = 1'b1;
    b_rst_n = 1'b0; b_data = 24'h32_2110; b_valid = 3'b111; b_mode = 1'b0;
    b_sel = 2'd3; b_qr = 1'b1;

    // Reset held two cycles with all channels valid
    tick(); tick();
    check_a("reset", 8'h00, 2'd0, 1'b0);
    check_eq("reset.ready", 32'(a_ready), 32'h0);

    a_rst_n = 1'b1;
    #1;
    check_eq("post_reset.ready", 32'(a_ready), 32'b0001);

    // Round-robin, all valid, back-to-back
    for (int i = 0; i < 5; i++) begin
      tick();
      check_a($sformatf("rr%0d", i), rr_q[i], rr_c[i], 1'b1);
    end

    a_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("alt%0d.chan", i), 32'(a_chan), 32'(alt_c[i]));
    end

    // Fixed mode
    a_mode = 1'b0; a_sel = 2'd2; a_valid = 4'b0100; a_data = 32'h43A5_2110;
    #1;
    check_eq("fix.ready", 32'(a_ready), 32'b0100);
    tick();
    check_a("fix", 8'hA5, 2'd2, 1'b1);
    a_valid = 4'b0001;
    #1;
    check_eq("fix_nogrant.ready", 32'(a_ready), 32'h0);
    tick();
    check_a("fix_nogrant", 8'hA5, 2'd2, 1'b0);

    // Backpressure
    a_data = 32'h4332_2110; a_sel = 2'd1; a_valid = 4'b0010;
    tick();
    check_a("bp_load", 8'h21, 2'd1, 1'b1);
    a_qr = 1'b0; a_sel = 2'd3; a_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp%0d.ready", i), 32'(a_ready), 32'h0);
      tick();
      check_a($sformatf("bp%0d", i), 8'h21, 2'd1, 1'b1);
    end
    a_qr = 1'b1;
    #1;
    check_eq("bp_release.ready", 32'(a_ready), 32'b1000);
    tick();
    check_a("bp_release", 8'h43, 2'd3, 1'b1);

    // Reset while a word is stalled
    a_qr = 1'b0; a_mode = 1'b1; a_valid = 4'b1111; a_rst_n = 1'b0;
    #1;
    check_eq("mid_reset.ready", 32'(a_ready), 32'h0);
    tick();
    check_a("mid_reset", 8'h00, 2'd0, 1'b0);
    a_rst_n = 1'b1; a_qr = 1'b1;
    #1;
    check_eq("mid_reset_rel.ready", 32'(a_ready), 32'b0001);
    tick();
    check_a("mid_reset_rel", 8'h10, 2'd0, 1'b1);

    // 3-channel instance: out-of-range select, then round-robin wrap
    b_rst_n = 1'b1;
    #1;
    check_eq("b_sel3.ready", 32'(b_ready), 32'h0);
    tick();
    check_eq("b_sel3.valid", 32'(b_qv), 32'h0);
    b_mode = 1'b1;
    #1;
    check_eq("b_rr.ready", 32'(b_ready), 32'b001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("b_rr%0d.chan", i), 32'(b_chan), 32'(i % 3));
      check_eq($sformatf("b_rr%0d.q", i), 32'(b_q), 32'((i % 3) * 8'h11 + 8'h10));
      check_eq($sformatf("b_rr%0d.valid", i), 32'(b_qv), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
